// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: FSM state encoding, frame width
// and baud counter width.
package uart_pkg;
  localparam int DATA_BITS = 8;
  localparam int CNT_W     = 16;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } state_e;
endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for the asynchronous rx pin; resets to the idle-high level.
module uart_sync (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);
  logic s1;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1 <= 1'b1;
      q  <= 1'b1;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end
endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a one-entry output holding register, a frame-error
// pulse on a bad stop bit and an overrun pulse when an unconsumed byte blocks delivery.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] recvData,
  output logic                 recvValid,
  input  logic                 recvAck,
  output logic                 frameErr,
  output logic                 overrun
);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] HALF    = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DATA_BITS - 1);

  logic                 rx_s;
  state_e               state;
  logic [CNT_W-1:0]     cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shreg;

  uart_sync u_sync (
    .clk  (clk),
    .rstn (rstn),
    .d    (rx),
    .q    (rx_s)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      recvData  <= '0;
      recvValid <= 1'b0;
      frameErr  <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frameErr <= 1'b0;
      overrun  <= 1'b0;
      // A delivery in the same cycle overrides this clear further down.
      if (recvValid && recvAck)
        recvValid <= 1'b0;

      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            cnt   <= '0;
          end
        end
        START: begin
          if (cnt == HALF) begin
            cnt <= '0;
            if (!rx_s) begin
              state   <= DATA;
              bit_idx <= '0;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (cnt == LAST) begin
            cnt     <= '0;
            shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
            bit_idx <= bit_idx + IDX_W'(1);
            if (bit_idx == IDX_MAX)
              state <= STOP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        STOP: begin
          if (cnt == LAST) begin
            cnt <= '0;
            if (rx_s) begin
              state <= IDLE;
              if (!recvValid || recvAck) begin
                recvData  <= shreg;
                recvValid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              frameErr <= 1'b1;
              state    <= WAIT_IDLE;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        WAIT_IDLE: begin
          // Hold here through a break so it reports only once.
          if (rx_s)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: expected bytes are queued as frames are driven
// and popped when the receiver presents a new byte.
module tb_uart_rx;
  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rstn;
  logic       rx;
  logic [7:0] recvData;
  logic       recvValid;
  logic       recvAck;
  logic       frameErr;
  logic       overrun;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int start_cyc = 0;
  int rise_cyc = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  logic       pv = 1'b0;
  logic [7:0] pd = 8'h00;
  logic [7:0] sb_q[$];

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .rx        (rx),
    .recvData  (recvData),
    .recvValid (recvValid),
    .recvAck   (recvAck),
    .frameErr  (frameErr),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Monitor: a new byte is a rising recvValid or a data change while valid.
  always @(posedge clk) begin
    logic [31:0] e;
    #1;
    if (frameErr) fe_cnt++;
    if (overrun)  ov_cnt++;
    if (recvValid && (!pv || recvData != pd)) begin
      if (!pv) rise_cyc = cyc;
      e = (sb_q.size() > 0) ? 32'(sb_q.pop_front()) : 32'h100;
      chk("sb_data", 32'(recvData), e);
    end
    pv = recvValid;
    pd = recvData;
  end

  // One frame, one cycle per iteration; optional ack and reset at given offsets.
  task automatic send_frame(input logic [7:0] b, input logic stop,
                            input int ack_k, input int rst_k);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int k = 0; k < 10 * CPB; k++) begin
      @(negedge clk);
      if (k == 0) start_cyc = cyc + 1;
      if (rst_k >= 0 && k == rst_k + 1) begin
        chk("rst_valid", 32'(recvValid), 32'd0);
        chk("rst_data",  32'(recvData),  32'd0);
        chk("rst_ferr",  32'(frameErr),  32'd0);
        chk("rst_ovr",   32'(overrun),   32'd0);
      end
      rstn    = (k != rst_k);
      recvAck = (k == ack_k);
      rx      = (rst_k >= 0 && k > rst_k) ? 1'b1 : fr[k / CPB];
    end
  endtask

  task automatic ack1();
    @(negedge clk) recvAck = 1'b1;
    @(negedge clk) recvAck = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rx = 1'b1; rstn = 1'b0; recvAck = 1'b0;
    idle(3);
    chk("reset_valid", 32'(recvValid), 32'd0);
    chk("reset_data",  32'(recvData),  32'd0);
    chk("reset_ferr",  32'(frameErr),  32'd0);
    chk("reset_ovr",   32'(overrun),   32'd0);
    rstn = 1'b1;
    idle(5);

    // Basic frame and latency
    sb_q.push_back(8'h55);
    send_frame(8'h55, 1'b1, -1, -1);
    idle(5);
    chk("lat_55",   32'(rise_cyc - start_cyc), 32'd155);
    chk("valid_55", 32'(recvValid), 32'd1);
    chk("data_55",  32'(recvData),  32'h55);
    ack1();
    chk("ack_clear_55", 32'(recvValid), 32'd0);

    // Short glitch is rejected
    @(negedge clk) rx = 1'b0;
    idle(4);
    rx = 1'b1;
    idle(200);
    chk("glitch_valid", 32'(recvValid), 32'd0);
    chk("glitch_ferr",  32'(fe_cnt), 32'd0);
    chk("glitch_ovr",   32'(ov_cnt), 32'd0);

    // Bad stop bit followed by a held-low break, then a good frame
    send_frame(8'hA3, 1'b0, -1, -1);
    idle(40);
    rx = 1'b1;
    idle(20);
    chk("break_ferr",  32'(fe_cnt), 32'd1);
    chk("break_valid", 32'(recvValid), 32'd0);
    sb_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1, -1, -1);
    idle(5);
    chk("valid_3c", 32'(recvValid), 32'd1);
    chk("data_3c",  32'(recvData),  32'h3C);
    chk("ferr_3c",  32'(fe_cnt), 32'd1);
    ack1();
    idle(2);

    // Overrun: second byte dropped while first is unconsumed
    sb_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, -1, -1);
    send_frame(8'h22, 1'b1, -1, -1);
    idle(5);
    chk("ovr_data",  32'(recvData),  32'h11);
    chk("ovr_valid", 32'(recvValid), 32'd1);
    chk("ovr_cnt",   32'(ov_cnt), 32'd1);
    ack1();
    chk("ovr_ack_clear", 32'(recvValid), 32'd0);

    // Ack coinciding with delivery replaces the byte without overrun
    sb_q.push_back(8'h11);
    sb_q.push_back(8'h22);
    send_frame(8'h11, 1'b1, -1, -1);
    send_frame(8'h22, 1'b1, 155, -1);
    idle(5);
    chk("same_cyc_data",  32'(recvData),  32'h22);
    chk("same_cyc_valid", 32'(recvValid), 32'd1);
    chk("same_cyc_ovr",   32'(ov_cnt), 32'd1);

    // Reset during data bit 3, then a clean frame
    send_frame(8'h99, 1'b1, -1, 4 * CPB + CPB / 2);
    idle(30);
    chk("post_rst_valid", 32'(recvValid), 32'd0);
    chk("post_rst_ferr",  32'(fe_cnt), 32'd1);
    sb_q.push_back(8'h7E);
    send_frame(8'h7E, 1'b1, -1, -1);
    idle(5);
    chk("valid_7e", 32'(recvValid), 32'd1);
    chk("data_7e",  32'(recvData),  32'h7E);
    chk("ovr_final", 32'(ov_cnt), 32'd1);

    chk("sb_left", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
